// File: rtl/teclado_ps2_pkg.sv
// Shared constants and event payload for the PS/2 keyboard event front end.
package teclado_ps2_pkg;

    localparam int unsigned CODE_W = 8;
    localparam int unsigned EV_W   = CODE_W + 2;

    localparam logic [CODE_W-1:0] PREFIX_EXT = 8'hE0;
    localparam logic [CODE_W-1:0] PREFIX_BRK = 8'hF0;

    // Status byte layout
    localparam int unsigned ST_NOT_EMPTY = 7;
    localparam int unsigned ST_FULL      = 6;
    localparam int unsigned ST_OVERFLOW  = 5;
    localparam int unsigned ST_PARITY    = 4;
    localparam int unsigned ST_FRAME     = 3;
    localparam int unsigned ST_IRQ_EN    = 2;
    localparam int unsigned ST_HEAD_EXT  = 1;
    localparam int unsigned ST_HEAD_BRK  = 0;

    // Control byte layout
    localparam int unsigned CTRL_CLR    = 0;
    localparam int unsigned CTRL_FLUSH  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    typedef struct packed {
        logic              ext;
        logic              brk;
        logic [CODE_W-1:0] code;
    } ps2_ev_t;

endpackage

// File: rtl/ps2_rx_filtrado.sv
// PS/2 receiver: input synchronisers, ps2c glitch filter, frame FSM with idle timeout.
module ps2_rx_filtrado
    import teclado_ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2d,
    input  logic              ps2c,
    output logic              byte_tick,
    output logic [CODE_W-1:0] byte_data,
    output logic              parity_err_tick,
    output logic              frame_err_tick
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic                  ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q;
    logic [FILTER_LEN-1:0] filt_sh_q, filt_sh_d;
    logic                  filt_clk_q, filt_clk_d;
    logic                  fall_q, fall_d;
    logic [1:0]            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [CODE_W-1:0]     shift_q, shift_d;
    logic                  par_q, par_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  byte_tick_q, byte_tick_d;
    logic [CODE_W-1:0]     byte_q, byte_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2c_s1_q   <= 1'b1;
            ps2c_s2_q   <= 1'b1;
            ps2d_s1_q   <= 1'b1;
            ps2d_s2_q   <= 1'b1;
            filt_sh_q   <= '1;
            filt_clk_q  <= 1'b1;
            fall_q      <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_tick_q <= 1'b0;
            byte_q      <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            ps2c_s1_q   <= ps2c;
            ps2c_s2_q   <= ps2c_s1_q;
            ps2d_s1_q   <= ps2d;
            ps2d_s2_q   <= ps2d_s1_q;
            filt_sh_q   <= filt_sh_d;
            filt_clk_q  <= filt_clk_d;
            fall_q      <= fall_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            byte_tick_q <= byte_tick_d;
            byte_q      <= byte_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    always_comb begin
        filt_sh_d   = {filt_sh_q[FILTER_LEN-2:0], ps2c_s2_q};
        filt_clk_d  = filt_clk_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = '0;
        byte_tick_d = 1'b0;
        byte_d      = byte_q;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;

        // Hysteresis: the filtered clock only moves once the whole window agrees
        if (&filt_sh_q) begin
            filt_clk_d = 1'b1;
        end else if (~|filt_sh_q) begin
            filt_clk_d = 1'b0;
        end
        fall_d = filt_clk_q & ~filt_clk_d;

        if (state_q != ST_IDLE) begin
            tmo_d = fall_q ? '0 : tmo_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_q && !ps2d_s2_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (fall_q) begin
                    shift_d   = {ps2d_s2_q, shift_q[CODE_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_q) begin
                    par_d   = ps2d_s2_q;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_q) begin
                    state_d = ST_IDLE;
                    perr_d  = ~(^{shift_q, par_q});
                    ferr_d  = ~ps2d_s2_q;
                    if (ps2d_s2_q && (^{shift_q, par_q})) begin
                        byte_tick_d = 1'b1;
                        byte_d      = shift_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stalled frame is abandoned so the next start bit is recognised
        if ((state_q != ST_IDLE) && !fall_q && (tmo_q == TW'(TIMEOUT_CYC - 1))) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
            tmo_d   = '0;
        end
    end

    assign byte_tick       = byte_tick_q;
    assign byte_data       = byte_q;
    assign parity_err_tick = perr_q;
    assign frame_err_tick  = ferr_q;

endmodule

// File: rtl/teclado_ps2_eventos.sv
// PS/2 keyboard event front end: prefix decoder, event FIFO and PicoBlaze port interface.
module teclado_ps2_eventos
    import teclado_ps2_pkg::*;
#(
    parameter int unsigned FIFO_AW         = 3,
    parameter int unsigned FILTER_LEN      = 8,
    parameter int unsigned TIMEOUT_CYC     = 50000,
    parameter bit          SUPPRESS_REPEAT = 1'b1,
    parameter logic [7:0]  PORT_DATA       = 8'h0F,
    parameter logic [7:0]  PORT_STATUS     = 8'h10,
    parameter logic [7:0]  PORT_CTRL       = 8'h11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       irq,
    output logic       fifo_full
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;

    logic              rx_tick, rx_perr, rx_ferr;
    logic [CODE_W-1:0] rx_byte;

    ps2_rx_filtrado #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk             (clk),
        .reset           (reset),
        .ps2d            (ps2d),
        .ps2c            (ps2c),
        .byte_tick       (rx_tick),
        .byte_data       (rx_byte),
        .parity_err_tick (rx_perr),
        .frame_err_tick  (rx_ferr)
    );

    ps2_ev_t           mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ext_q, ext_d, brk_q, brk_d;
    logic              lm_ext_q, lm_ext_d, lm_valid_q, lm_valid_d;
    logic [CODE_W-1:0] lm_code_q, lm_code_d;
    logic              perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic              irq_en_q, irq_en_d;
    logic [7:0]        in_port_q, in_port_d;
    logic              irq_q, irq_d, full_q, full_d;

    logic              ctrl_wr_c, flush_c, clr_c, not_empty_c, full_c, pop_c;
    logic              push_req_c, push_c, same_make_c;
    ps2_ev_t           head_c, push_ev_c;
    logic [7:0]        status_c;
    logic              unused_ok_c;

    assign unused_ok_c = &{1'b0, out_port[7:3]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            lm_ext_q   <= 1'b0;
            lm_code_q  <= '0;
            lm_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            in_port_q  <= 8'h00;
            irq_q      <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            lm_ext_q   <= lm_ext_d;
            lm_code_q  <= lm_code_d;
            lm_valid_q <= lm_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            in_port_q  <= in_port_d;
            irq_q      <= irq_d;
            full_q     <= full_d;
        end
    end

    // Event storage carries no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= push_ev_c;
        end
    end

    always_comb begin
        ctrl_wr_c   = write_strobe && (port_id == PORT_CTRL);
        flush_c     = ctrl_wr_c && out_port[CTRL_FLUSH];
        clr_c       = ctrl_wr_c && out_port[CTRL_CLR];
        not_empty_c = (cnt_q != '0);
        full_c      = (cnt_q == CW'(DEPTH));
        head_c      = not_empty_c ? mem_q[rd_ptr_q] : '0;
        pop_c       = read_strobe && (port_id == PORT_DATA) && not_empty_c;

        ext_d       = ext_q;
        brk_d       = brk_q;
        lm_ext_d    = lm_ext_q;
        lm_code_d   = lm_code_q;
        lm_valid_d  = lm_valid_q;
        push_req_c  = 1'b0;
        push_ev_c   = '{ext: ext_q, brk: brk_q, code: rx_byte};
        same_make_c = lm_valid_q && (lm_ext_q == ext_q) && (lm_code_q == rx_byte);

        if (rx_tick) begin
            if (rx_byte == PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d      = 1'b0;
                brk_d      = 1'b0;
                push_req_c = 1'b1;
                if (brk_q) begin
                    if (same_make_c) begin
                        lm_valid_d = 1'b0;
                    end
                end else begin
                    if (SUPPRESS_REPEAT && same_make_c) begin
                        push_req_c = 1'b0;
                    end
                    lm_ext_d   = ext_q;
                    lm_code_d  = rx_byte;
                    lm_valid_d = 1'b1;
                end
            end
        end

        // Flush beats any event decoded in the same cycle
        if (flush_c) begin
            ext_d      = 1'b0;
            brk_d      = 1'b0;
            lm_valid_d = 1'b0;
            push_req_c = 1'b0;
        end

        push_c   = push_req_c && (!full_c || pop_c);
        wr_ptr_d = wr_ptr_q + FIFO_AW'(push_c);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(pop_c);
        cnt_d    = cnt_q + CW'(push_c) - CW'(pop_c);
        if (flush_c) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end

        perr_d   = rx_perr | (perr_q & ~clr_c);
        ferr_d   = rx_ferr | (ferr_q & ~clr_c);
        ovf_d    = (push_req_c && full_c && !pop_c) | (ovf_q & ~clr_c);
        irq_en_d = ctrl_wr_c ? out_port[CTRL_IRQ_EN] : irq_en_q;

        status_c               = 8'h00;
        status_c[ST_NOT_EMPTY] = not_empty_c;
        status_c[ST_FULL]      = full_c;
        status_c[ST_OVERFLOW]  = ovf_q;
        status_c[ST_PARITY]    = perr_q;
        status_c[ST_FRAME]     = ferr_q;
        status_c[ST_IRQ_EN]    = irq_en_q;
        status_c[ST_HEAD_EXT]  = head_c.ext;
        status_c[ST_HEAD_BRK]  = head_c.brk;

        if (port_id == PORT_DATA) begin
            in_port_d = head_c.code;
        end else if (port_id == PORT_STATUS) begin
            in_port_d = status_c;
        end else begin
            in_port_d = 8'h00;
        end

        irq_d  = irq_en_q & not_empty_c;
        full_d = (cnt_d == CW'(DEPTH));
    end

    assign in_port   = in_port_q;
    assign irq       = irq_q;
    assign fifo_full = full_q;

endmodule

// File: tb/tb_teclado_ps2_eventos.sv
// Directed bench for teclado_ps2_eventos: PS/2 frames in, PicoBlaze port reads out.
module tb_teclado_ps2_eventos;

    localparam int unsigned TMO      = 1000;
    localparam logic [7:0]  P_DATA   = 8'h0F;
    localparam logic [7:0]  P_STATUS = 8'h10;
    localparam logic [7:0]  P_CTRL   = 8'h11;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2d = 1'b1;
    logic       ps2c = 1'b1;
    logic [7:0] port_id = 8'h00;
    logic       read_strobe = 1'b0;
    logic       write_strobe = 1'b0;
    logic [7:0] out_port = 8'h00;
    logic [7:0] in_port, in_port_nr;
    logic       irq, irq_nr, fifo_full, fifo_full_nr;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    teclado_ps2_eventos #(
        .FIFO_AW(3), .FILTER_LEN(8), .TIMEOUT_CYC(TMO), .SUPPRESS_REPEAT(1'b1),
        .PORT_DATA(P_DATA), .PORT_STATUS(P_STATUS), .PORT_CTRL(P_CTRL)
    ) dut (
        .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .port_id(port_id),
        .read_strobe(read_strobe), .write_strobe(write_strobe), .out_port(out_port),
        .in_port(in_port), .irq(irq), .fifo_full(fifo_full)
    );

    teclado_ps2_eventos #(
        .FIFO_AW(3), .FILTER_LEN(8), .TIMEOUT_CYC(TMO), .SUPPRESS_REPEAT(1'b0),
        .PORT_DATA(P_DATA), .PORT_STATUS(P_STATUS), .PORT_CTRL(P_CTRL)
    ) dut_nr (
        .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .port_id(port_id),
        .read_strobe(read_strobe), .write_strobe(write_strobe), .out_port(out_port),
        .in_port(in_port_nr), .irq(irq_nr), .fifo_full(fifo_full_nr)
    );

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2d = b;
        wait_cyc(10);
        ps2c = 1'b0;
        wait_cyc(20);
        ps2c = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(~(^code) ^ bad_par);
        send_bit(1'b1);
        ps2d = 1'b1;
        wait_cyc(20);
    endtask

    // Port held one cycle before the optional strobe, as the PicoBlaze does
    task automatic read_bus(input logic [7:0] p, input logic pop,
                            output logic [7:0] v, output logic [7:0] v_nr);
        @(negedge clk);
        port_id = p;
        @(negedge clk);
        v    = in_port;
        v_nr = in_port_nr;
        read_strobe = pop;
        @(negedge clk);
        read_strobe = 1'b0;
        port_id = 8'h00;
    endtask

    task automatic write_ctrl(input logic [7:0] v);
        @(negedge clk);
        port_id = P_CTRL;
        out_port = v;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
        port_id = 8'h00;
        out_port = 8'h00;
    endtask

    task automatic test_reset;
        logic [7:0] v, vn;
        reset = 1'b0;
        wait_cyc(3);
        ncmp++; if (in_port !== 8'h00) begin nerr++; $display("FAIL reset_in_port got %h want 00", in_port); end
        ncmp++; if (irq !== 1'b0) begin nerr++; $display("FAIL reset_irq got %b want 0", irq); end
        ncmp++; if (fifo_full !== 1'b0) begin nerr++; $display("FAIL reset_fifo_full got %b want 0", fifo_full); end
        reset = 1'b1;
        wait_cyc(3);
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'h00) begin nerr++; $display("FAIL reset_status got %h want 00", v); end
        read_bus(P_DATA, 1'b1, v, vn);
        ncmp++; if (v !== 8'h00) begin nerr++; $display("FAIL empty_pop_data got %h want 00", v); end
    endtask

    task automatic test_make_break;
        logic [7:0] v, vn;
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'h80) begin nerr++; $display("FAIL mb_status1 got %h want 80", v); end
        read_bus(P_DATA, 1'b1, v, vn);
        ncmp++; if (v !== 8'h1C) begin nerr++; $display("FAIL mb_data1 got %h want 1c", v); end
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'h81) begin nerr++; $display("FAIL mb_status2 got %h want 81", v); end
        read_bus(P_DATA, 1'b1, v, vn);
        ncmp++; if (v !== 8'h1C) begin nerr++; $display("FAIL mb_data2 got %h want 1c", v); end
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'h00) begin nerr++; $display("FAIL mb_empty got %h want 00", v); end
        ncmp++; if (irq !== 1'b0) begin nerr++; $display("FAIL mb_irq_off got %b want 0", irq); end
    endtask

    task automatic test_extended;
        logic [7:0] v, vn;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'h82) begin nerr++; $display("FAIL ext_status1 got %h want 82", v); end
        read_bus(P_DATA, 1'b1, v, vn);
        ncmp++; if (v !== 8'h75) begin nerr++; $display("FAIL ext_data1 got %h want 75", v); end
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'h83) begin nerr++; $display("FAIL ext_status2 got %h want 83", v); end
        read_bus(P_DATA, 1'b1, v, vn);
        ncmp++; if (v !== 8'h75) begin nerr++; $display("FAIL ext_data2 got %h want 75", v); end
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'h00) begin nerr++; $display("FAIL ext_only_two got %h want 00", v); end
    endtask

    task automatic test_repeat;
        logic [7:0] v, vn;
        logic [7:0] exp_st [4]    = '{8'h80, 8'h81, 8'h00, 8'h00};
        logic [7:0] exp_d  [4]    = '{8'h05, 8'h05, 8'h00, 8'h00};
        logic [7:0] exp_st_nr [4] = '{8'h80, 8'h80, 8'h80, 8'h81};
        write_ctrl(8'h03);
        for (int i = 0; i < 3; i++) send_frame(8'h05, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h05, 1'b0);
        for (int i = 0; i < 4; i++) begin
            read_bus(P_STATUS, 1'b0, v, vn);
            ncmp++; if (v !== exp_st[i]) begin nerr++; $display("FAIL rep_status[%0d] got %h want %h", i, v, exp_st[i]); end
            ncmp++; if (vn !== exp_st_nr[i]) begin nerr++; $display("FAIL norep_status[%0d] got %h want %h", i, vn, exp_st_nr[i]); end
            read_bus(P_DATA, 1'b1, v, vn);
            ncmp++; if (v !== exp_d[i]) begin nerr++; $display("FAIL rep_data[%0d] got %h want %h", i, v, exp_d[i]); end
            ncmp++; if (vn !== 8'h05) begin nerr++; $display("FAIL norep_data[%0d] got %h want 05", i, vn); end
        end
    endtask

    task automatic test_parity;
        logic [7:0] v, vn;
        send_frame(8'h33, 1'b1);
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'h10) begin nerr++; $display("FAIL par_status got %h want 10", v); end
        write_ctrl(8'h01);
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'h00) begin nerr++; $display("FAIL par_clear got %h want 00", v); end
    endtask

    task automatic test_overflow;
        logic [7:0] v, vn;
        logic [7:0] code;
        write_ctrl(8'h03);
        for (int i = 1; i <= 10; i++) begin
            code = 8'(i);
            send_frame(code, 1'b0);
        end
        ncmp++; if (fifo_full !== 1'b1) begin nerr++; $display("FAIL ovf_full got %b want 1", fifo_full); end
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'hE0) begin nerr++; $display("FAIL ovf_status got %h want e0", v); end
        for (int i = 1; i <= 8; i++) begin
            code = 8'(i);
            read_bus(P_DATA, 1'b1, v, vn);
            ncmp++; if (v !== code) begin nerr++; $display("FAIL ovf_data[%0d] got %h want %h", i, v, code); end
        end
        ncmp++; if (fifo_full !== 1'b0) begin nerr++; $display("FAIL ovf_drained_full got %b want 0", fifo_full); end
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'h20) begin nerr++; $display("FAIL ovf_sticky got %h want 20", v); end
        write_ctrl(8'h01);
    endtask

    task automatic test_timeout;
        logic [7:0] v, vn;
        write_ctrl(8'h05);
        wait_cyc(2);
        ncmp++; if (irq !== 1'b0) begin nerr++; $display("FAIL tmo_irq_idle got %b want 0", irq); end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2d = 1'b1;
        wait_cyc(TMO + 200);
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'h0C) begin nerr++; $display("FAIL tmo_status got %h want 0c", v); end
        send_frame(8'h1C, 1'b0);
        ncmp++; if (irq !== 1'b1) begin nerr++; $display("FAIL tmo_irq_rise got %b want 1", irq); end
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'h8C) begin nerr++; $display("FAIL tmo_status2 got %h want 8c", v); end
        read_bus(P_DATA, 1'b1, v, vn);
        ncmp++; if (v !== 8'h1C) begin nerr++; $display("FAIL tmo_data got %h want 1c", v); end
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (irq !== 1'b0) begin nerr++; $display("FAIL tmo_irq_fall got %b want 0", irq); end
    endtask

    task automatic test_flush;
        logic [7:0] v, vn;
        write_ctrl(8'h01);
        send_frame(8'h2A, 1'b0);
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'h80) begin nerr++; $display("FAIL flush_pre got %h want 80", v); end
        write_ctrl(8'h02);
        read_bus(P_STATUS, 1'b0, v, vn);
        ncmp++; if (v !== 8'h00) begin nerr++; $display("FAIL flush_status got %h want 00", v); end
        read_bus(P_DATA, 1'b1, v, vn);
        ncmp++; if (v !== 8'h00) begin nerr++; $display("FAIL flush_data got %h want 00", v); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_repeat();
        test_parity();
        test_overflow();
        test_timeout();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
